perceptron_trainer_n: RTL
=========================

Name: perceptron_trainer_n

Overview:
- Parametrised single-layer perceptron trainer with N_IN inputs.
- Holds an on-chip sample buffer and a controller FSM that runs the perceptron rule epoch by epoch.
- Stops on convergence (an error-free epoch) or when MAX_EPOCHS is reached.
- Successor to the fixed 2-input training datapath: generalised input count, widths, learning rate and depth, with an integrated controller and status outputs.

Parameters:
- N_IN, 2, number of inputs/weights
- XW, 7, signed input width
- WW, 14, signed weight/bias width
- DEPTH, 16, sample buffer entries
- ALPHA, 1, learning rate (integer, weight-LSB units)
- MAX_EPOCHS, 255, epoch limit (>=1)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- wr_en  in  1  buffer write strobe
- wr_addr  in  clog2(DEPTH)  write address
- wr_x  in  N_IN*XW  packed signed inputs, x[i] at bits [i*XW +: XW]
- wr_t  in  1  target: 1 = +1, 0 = -1
- num_samples  in  clog2(DEPTH)+1  samples per epoch, sampled at start
- start  in  1  begin training (pulse)
- busy  out  1  training in progress
- done  out  1  training finished; held until next accepted start
- converged  out  1  last completed epoch had zero errors
- epoch_cnt  out  8  epochs completed
- err_cnt  out  clog2(DEPTH)+1  errors in current/last epoch
- weights  out  N_IN*WW  packed signed weights
- bias  out  WW  signed bias

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: all outputs 0; FSM in IDLE; buffer contents undefined.
- Reset asserted mid-training aborts immediately to IDLE with all outputs 0.
- Buffer writes: accepted only when busy=0. While busy=1, wr_en is ignored.
- Start: accepted only in IDLE or DONE_S.
  - On acceptance: weights, bias, epoch_cnt, err_cnt, converged and done cleared; num_samples latched; busy=1 from the next cycle.
  - start while busy is ignored.
- FSM states: IDLE, FETCH, YIN, UPDATE, CHECK, DONE_S. Sample index k starts at 0.
- FETCH (1 cycle): registered read of buffer[k].
- YIN (1 cycle):
  - yin = sum(x[i]*w[i]) + bias, computed full-precision signed.
  - Accumulator width: XW+WW+clog2(N_IN)+1. No truncation.
- UPDATE (1 cycle):
  - y = +1 if yin >= 0, else -1 (yin == 0 gives +1).
  - If y != t: w[i] += ALPHA*t*x[i]; bias += ALPHA*t; err_cnt++.
  - If y == t: no change.
  - Results are truncated to WW bits (two's-complement wrap) unless the optional feature is enabled.
  - Next state: FETCH with k+1 if k+1 < latched num_samples, else CHECK.
- CHECK (1 cycle):
  - epoch_cnt++.
  - If err_cnt == 0: converged=1, go to DONE_S.
  - Else if epoch_cnt (new value) == MAX_EPOCHS: converged=0, go to DONE_S.
  - Else: err_cnt=0, k=0, go to FETCH.
- DONE_S: busy=0, done=1. Weights, bias and counters hold until the next accepted start.
- num_samples == 0: after start goes straight to CHECK (err_cnt 0), so epoch_cnt=1, converged=1.
- num_samples > DEPTH: clamped to DEPTH.
- Latency: each epoch takes 3*num_samples+1 cycles.

Optional Feature:
- Macro: PERCEPTRON_SATURATE_EN.
- Defined: weight and bias updates saturate to [-2^(WW-1), 2^(WW-1)-1].
- Undefined: updates wrap modulo 2^WW.

Test Plan:
- Bipolar AND (N_IN=2, ALPHA=1), samples (1,1,+1), (1,-1,-1), (-1,1,-1), (-1,-1,-1), num_samples=4, start -> done after 39 busy cycles; converged=1, epoch_cnt=3, weights=(1,1), bias=-1.
- XOR samples (1,1,-1), (1,-1,+1), (-1,1,+1), (-1,-1,-1), MAX_EPOCHS=5 -> done, converged=0, epoch_cnt=5, err_cnt>0.
- WW=4, ALPHA=4, MAX_EPOCHS=1, one sample x=(3,0), t=-1 -> without macro w[0]=4, bias=-4; with PERCEPTRON_SATURATE_EN w[0]=-8, bias=-4.
- num_samples=0, start -> busy for 1 cycle, then done=1, converged=1, epoch_cnt=1, weights=0.
- Pulse rst_n low mid-epoch 2 of the AND run -> all outputs 0 asynchronously; a restart reproduces the scenario-1 result.
- wr_en to buffer[0] and start pulses while busy -> both ignored; AND result unchanged.

Source files
------------

// File: rtl/perceptron_trainer_n.sv
// Single-layer perceptron trainer: sample buffer plus epoch controller running the perceptron rule.
// Optional build macro PERCEPTRON_SATURATE_EN makes weight/bias updates saturate instead of wrap.
module perceptron_trainer_n #(
    parameter int N_IN       = 2,
    parameter int XW         = 7,
    parameter int WW         = 14,
    parameter int DEPTH      = 16,
    parameter int ALPHA      = 1,
    parameter int MAX_EPOCHS = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [N_IN*XW-1:0]         wr_x,
    input  logic                       wr_t,
    input  logic [$clog2(DEPTH):0]     num_samples,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       converged,
    output logic [7:0]                 epoch_cnt,
    output logic [$clog2(DEPTH):0]     err_cnt,
    output logic [N_IN*WW-1:0]         weights,
    output logic [WW-1:0]              bias
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int ACCW = XW + WW + $clog2(N_IN) + 1;
    localparam int SW   = WW + XW + 34;
    localparam int BW   = N_IN * XW + 1;
    localparam logic signed [SW-1:0] ALPHA_S = SW'(ALPHA);

`ifdef PERCEPTRON_SATURATE_EN
    localparam logic signed [SW-1:0] W_MAX = $signed({{(SW-WW+1){1'b0}}, {(WW-1){1'b1}}});
    localparam logic signed [SW-1:0] W_MIN = $signed({{(SW-WW+1){1'b1}}, {(WW-1){1'b0}}});
`endif

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        YIN,
        UPDATE,
        CHECK,
        DONE_S
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       k_q, k_d;
    logic [CW-1:0]       n_q, n_d;
    logic [N_IN*WW-1:0]  w_q, w_d;
    logic [WW-1:0]       b_q, b_d;
    logic [7:0]          epoch_q, epoch_d;
    logic [CW-1:0]       err_q, err_d;
    logic                conv_q, conv_d;
    logic                yin_neg_q, yin_neg_d;

    // Sample buffer word: {x[N_IN-1] .. x[0], t}
    logic [BW-1:0]       mem [DEPTH];
    logic [BW-1:0]       rd_q;

    logic signed [XW-1:0] x_arr [N_IN];
    logic signed [WW-1:0] w_arr [N_IN];
    logic                 sample_t;

    logic signed [ACCW-1:0] yin_sum, acc_x, acc_w;
    logic signed [SW-1:0]   step, u_x, u_w, u_sum;
    logic [N_IN*WW-1:0]     w_upd;
    logic [WW-1:0]          b_upd;
    logic                   mismatch;
    logic [CW-1:0]          k_inc;
    logic [CW-1:0]          n_clamp;

    function automatic logic [WW-1:0] fit(input logic signed [SW-1:0] v);
`ifdef PERCEPTRON_SATURATE_EN
        if (v > W_MAX) begin
            return W_MAX[WW-1:0];
        end else if (v < W_MIN) begin
            return W_MIN[WW-1:0];
        end
        return v[WW-1:0];
`else
        return v[WW-1:0];
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            mem[wr_addr] <= {wr_x, wr_t};
        end
        if (state_q == FETCH) begin
            rd_q <= mem[k_q];
        end
    end

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_unpack
            assign x_arr[gi] = rd_q[1 + gi*XW +: XW];
            assign w_arr[gi] = w_q[gi*WW +: WW];
        end
    endgenerate
    assign sample_t = rd_q[0];

    // Full-width dot product; only its sign is kept since that alone decides y.
    always_comb begin
        acc_x   = '0;
        acc_w   = $signed(b_q);
        yin_sum = acc_w;
        for (int i = 0; i < N_IN; i++) begin
            acc_x   = x_arr[i];
            acc_w   = w_arr[i];
            yin_sum = yin_sum + acc_x * acc_w;
        end
    end

    always_comb begin
        step  = sample_t ? ALPHA_S : -ALPHA_S;
        u_x   = '0;
        u_w   = '0;
        u_sum = '0;
        w_upd = w_q;
        for (int i = 0; i < N_IN; i++) begin
            u_x   = x_arr[i];
            u_w   = w_arr[i];
            u_sum = u_w + step * u_x;
            w_upd[i*WW +: WW] = fit(u_sum);
        end
        u_w   = $signed(b_q);
        b_upd = fit(u_w + step);
    end

    // y is +1 when yin >= 0, so a mismatch is sign bit equal to the target bit.
    assign mismatch = (yin_neg_q == sample_t);
    assign k_inc    = {1'b0, k_q} + CW'(1);
    assign n_clamp  = (num_samples > CW'(DEPTH)) ? CW'(DEPTH) : num_samples;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        n_d       = n_q;
        w_d       = w_q;
        b_d       = b_q;
        epoch_d   = epoch_q;
        err_d     = err_q;
        conv_d    = conv_q;
        yin_neg_d = yin_neg_q;
        case (state_q)
            IDLE, DONE_S: begin
                if (start) begin
                    w_d     = '0;
                    b_d     = '0;
                    epoch_d = '0;
                    err_d   = '0;
                    conv_d  = 1'b0;
                    k_d     = '0;
                    n_d     = n_clamp;
                    state_d = (n_clamp == '0) ? CHECK : FETCH;
                end
            end
            FETCH: begin
                state_d = YIN;
            end
            YIN: begin
                yin_neg_d = yin_sum[ACCW-1];
                state_d   = UPDATE;
            end
            UPDATE: begin
                if (mismatch) begin
                    w_d   = w_upd;
                    b_d   = b_upd;
                    err_d = err_q + CW'(1);
                end
                if (k_inc < n_q) begin
                    k_d     = k_inc[AW-1:0];
                    state_d = FETCH;
                end else begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                epoch_d = epoch_q + 8'd1;
                if (err_q == '0) begin
                    conv_d  = 1'b1;
                    state_d = DONE_S;
                end else if (epoch_d == 8'(MAX_EPOCHS)) begin
                    conv_d  = 1'b0;
                    state_d = DONE_S;
                end else begin
                    err_d   = '0;
                    k_d     = '0;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_q       <= '0;
            n_q       <= '0;
            w_q       <= '0;
            b_q       <= '0;
            epoch_q   <= '0;
            err_q     <= '0;
            conv_q    <= 1'b0;
            yin_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            n_q       <= n_d;
            w_q       <= w_d;
            b_q       <= b_d;
            epoch_q   <= epoch_d;
            err_q     <= err_d;
            conv_q    <= conv_d;
            yin_neg_q <= yin_neg_d;
        end
    end

    assign busy      = (state_q == FETCH) || (state_q == YIN) ||
                       (state_q == UPDATE) || (state_q == CHECK);
    assign done      = (state_q == DONE_S);
    assign converged = conv_q;
    assign epoch_cnt = epoch_q;
    assign err_cnt   = err_q;
    assign weights   = w_q;
    assign bias      = b_q;

endmodule
